act_sram_arbiter: RTL and testbench

//  Shares the two ports of the 4096x128b activation SRAM among NUM_REQ requesters (DMA loader,

---
 rtl/act_sram_pkg.sv | 14 +
 rtl/act_sram_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 32 +++
 rtl/act_sram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_act_sram_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_sram_pkg.sv
// rtl/act_sram_pkg.sv - shared widths and helpers for the activation SRAM arbiter
package act_sram_pkg;

    localparam int ACT_ADDR_W = 16;
    localparam int ACT_DATA_W = 128;
    localparam int ACT_BE_W   = 16;
    localparam int ACT_DEPTH  = 4096;

    // An all-zero byte-enable word marks a read request
    function automatic logic is_read(input logic [ACT_BE_W-1:0] be);
        return (be == '0);
    endfunction

endpackage

// File: rtl/act_sram_arbiter_if.sv
// rtl/act_sram_arbiter_if.sv - requester-side request/response bus of the activation SRAM arbiter
interface act_sram_arbiter_if
    import act_sram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ACT_ADDR_W,
    parameter int DATA_W  = ACT_DATA_W
);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ-1:0][ACT_BE_W-1:0] req_be;
    logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;

    modport master (
        output req_valid, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin first-one finder starting at a pointer, with an exclude mask
module rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    input  logic [N-1:0]     excl,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cur;

    // Walk the requesters once in ring order from start; the first eligible one wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cur   = start;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[cur] && !excl[cur]) begin
                found      = 1'b1;
                grant[cur] = 1'b1;
                idx        = cur;
            end
            cur = (cur == IDX_W'(N - 1)) ? '0 : cur + 1'b1;
        end
    end

endmodule

// File: rtl/act_sram_arbiter.sv
// rtl/act_sram_arbiter.sv - two-port round-robin arbiter in front of the activation SRAM
module act_sram_arbiter
    import act_sram_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = ACT_ADDR_W,
    parameter  int DATA_W  = ACT_DATA_W,
    parameter  int DEPTH   = ACT_DEPTH,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    act_sram_arbiter_if.slave   bus,
    output logic                oob_err,
    output logic [ACT_BE_W-1:0] sram_wea0,
    output logic [ADDR_W-1:0]   sram_addr0,
    output logic [DATA_W-1:0]   sram_wdata0,
    input  logic [DATA_W-1:0]   sram_rdata0,
    output logic [ACT_BE_W-1:0] sram_wea1,
    output logic [ADDR_W-1:0]   sram_addr1,
    output logic [DATA_W-1:0]   sram_wdata1,
    input  logic [DATA_W-1:0]   sram_rdata1
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic               rsp_port_q, rsp_port_d;
    logic               rsp_oob_q, rsp_oob_d;
    logic               oob_err_q, oob_err_d;

    logic [NUM_REQ-1:0] grant_a, grant_b;
    logic [IDX_W-1:0]   idx_a, idx_b, start_b;
    logic               found_a, found_b;

    logic [ADDR_W-1:0]   addr_a, addr_b;
    logic [ACT_BE_W-1:0] be_a, be_b;
    logic [DATA_W-1:0]   wdata_a, wdata_b;
    logic                rd_a, rd_b, oob_a, oob_b;
    logic                conflict, two_reads, acc_a, acc_b;

    // B searches from the slot just after A, so it is the next requester in ring order
    assign start_b = (idx_a == IDX_W'(NUM_REQ - 1)) ? '0 : idx_a + 1'b1;

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .valid (bus.req_valid),
        .start (rr_ptr_q),
        .excl  ({NUM_REQ{1'b0}}),
        .grant (grant_a),
        .idx   (idx_a),
        .found (found_a)
    );

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .valid (bus.req_valid),
        .start (start_b),
        .excl  (grant_a),
        .grant (grant_b),
        .idx   (idx_b),
        .found (found_b)
    );

    // Qualify the two winners: B yields on a same-row write hazard or when both would read
    always_comb begin
        addr_a    = bus.req_addr[idx_a];
        addr_b    = bus.req_addr[idx_b];
        be_a      = bus.req_be[idx_a];
        be_b      = bus.req_be[idx_b];
        wdata_a   = bus.req_wdata[idx_a];
        wdata_b   = bus.req_wdata[idx_b];
        rd_a      = is_read(be_a);
        rd_b      = is_read(be_b);
        oob_a     = ({1'b0, addr_a} >= DEPTH_X);
        oob_b     = ({1'b0, addr_b} >= DEPTH_X);
        conflict  = (addr_a == addr_b) && !(rd_a && rd_b);
        two_reads = rd_a && rd_b;
        acc_a     = found_a && rst_n;
        acc_b     = found_b && rst_n && !conflict && !two_reads;
        bus.req_ready = (acc_a ? grant_a : '0) | (acc_b ? grant_b : '0);
    end

    // Drive the SRAM ports; out-of-range and idle ports park on row 0 with no write
    always_comb begin
        sram_wea0   = '0;
        sram_addr0  = '0;
        sram_wdata0 = '0;
        sram_wea1   = '0;
        sram_addr1  = '0;
        sram_wdata1 = '0;
        if (acc_a && !oob_a) begin
            sram_wea0   = be_a;
            sram_addr0  = addr_a;
            sram_wdata0 = wdata_a;
        end
        if (acc_b && !oob_b) begin
            sram_wea1   = be_b;
            sram_addr1  = addr_b;
            sram_wdata1 = wdata_b;
        end
    end

    // Next pointer, read-response tag and sticky error
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rsp_vld_d  = 1'b0;
        rsp_idx_d  = rsp_idx_q;
        rsp_port_d = rsp_port_q;
        rsp_oob_d  = rsp_oob_q;
        oob_err_d  = oob_err_q | (acc_a & oob_a) | (acc_b & oob_b);
        if (acc_b) begin
            rr_ptr_d = (idx_b == IDX_W'(NUM_REQ - 1)) ? '0 : idx_b + 1'b1;
        end else if (acc_a) begin
            rr_ptr_d = start_b;
        end
        if (acc_a && rd_a) begin
            rsp_vld_d  = 1'b1;
            rsp_idx_d  = idx_a;
            rsp_port_d = 1'b0;
            rsp_oob_d  = oob_a;
        end else if (acc_b && rd_b) begin
            rsp_vld_d  = 1'b1;
            rsp_idx_d  = idx_b;
            rsp_port_d = 1'b1;
            rsp_oob_d  = oob_b;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_idx_q  <= '0;
            rsp_port_q <= 1'b0;
            rsp_oob_q  <= 1'b0;
            oob_err_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_port_q <= rsp_port_d;
            rsp_oob_q  <= rsp_oob_d;
            oob_err_q  <= oob_err_d;
        end
    end

    // Return read data to the tagged requester; out-of-range reads return zero
    always_comb begin
        bus.rsp_valid = rsp_vld_q ? (NUM_REQ'(1) << rsp_idx_q) : '0;
        bus.rsp_rdata = '0;
        if (rsp_vld_q && !rsp_oob_q) begin
            bus.rsp_rdata = rsp_port_q ? sram_rdata1 : sram_rdata0;
        end
    end

    assign oob_err = oob_err_q;

endmodule

// File: tb/tb_act_sram_arbiter.sv
// tb/tb_act_sram_arbiter.sv - self-checking bench for act_sram_arbiter
module tb_act_sram_arbiter;
    import act_sram_pkg::*;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    act_sram_arbiter_if #(.NUM_REQ(NR)) bus ();

    logic         oob_err;
    logic [15:0]  sram_wea0, sram_wea1, sram_addr0, sram_addr1;
    logic [127:0] sram_wdata0, sram_wdata1, sram_rdata0, sram_rdata1;

    act_sram_arbiter #(.NUM_REQ(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .oob_err     (oob_err),
        .sram_wea0   (sram_wea0),
        .sram_addr0  (sram_addr0),
        .sram_wdata0 (sram_wdata0),
        .sram_rdata0 (sram_rdata0),
        .sram_wea1   (sram_wea1),
        .sram_addr1  (sram_addr1),
        .sram_wdata1 (sram_wdata1),
        .sram_rdata1 (sram_rdata1)
    );

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                           input logic [15:0] be);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Dual-port SRAM environment model: registered read, byte-enabled write
    logic [127:0] sram_mem [int];
    function automatic logic [127:0] sram_rd(input logic [15:0] a);
        return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : 128'h0;
    endfunction
    always @(posedge clk) begin
        sram_rdata0 <= sram_rd(sram_addr0);
        sram_rdata1 <= sram_rd(sram_addr1);
        if (sram_wea0 != 16'h0) sram_mem[int'(sram_addr0)] = merge(sram_rd(sram_addr0), sram_wdata0, sram_wea0);
        if (sram_wea1 != 16'h0) sram_mem[int'(sram_addr1)] = merge(sram_rd(sram_addr1), sram_wdata1, sram_wea1);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] be,
                         input logic [15:0] a, input logic [127:0] wd);
        bus.req_valid[i] = v;
        bus.req_be[i]    = be;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = wd;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NR; i++) drive(i, 1'b0, 16'h0, 16'h0, 128'h0);
    endtask

    typedef struct {
        logic [3:0]       v;
        logic [3:0]       wr;
        logic [3:0][15:0] addr;
        logic [3:0][7:0]  wb;
        logic [3:0]       ready;
        logic [3:0]       rsp;
        logic [7:0]       rb;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] wr,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] a3,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [3:0] rdy, input logic [3:0] rsp,
                                input logic [7:0] rb);
        vec_t t;
        t.v = v; t.wr = wr; t.addr = {a3, a2, a1, a0}; t.wb = {b3, b2, b1, b0};
        t.ready = rdy; t.rsp = rsp; t.rb = rb;
        return t;
    endfunction

    vec_t tbl[$];
    vec_t cv;

    // Reference model state for the randomized phase
    logic [127:0] shadow [0:4095];
    logic [3:0]   p_v, p_wr, m_acc, m_rsp_v;
    logic [15:0]  p_be   [NR];
    logic [15:0]  p_addr [NR];
    logic [127:0] p_wd   [NR];
    logic [127:0] m_rsp_d;
    logic         m_oob, haz;
    int           m_ptr, last, a, b, ix;
    int           q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 4096; r++) shadow[r] = 128'h0;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'h0);
        chk("reset_oob_err", 128'(oob_err), 128'h0);
        chk("reset_ready", 128'(bus.req_ready), 128'h0);
        rst_n = 1'b1;

        // Directed cycle table: single read, same-row write hazard, four writers, read pair
        tbl.push_back(mk(4'b0001, 4'b0001, 5, 0, 0, 0, 8'hA5, 0, 0, 0, 4'b0001, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0010, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 8'hA5));
        tbl.push_back(mk(4'b0011, 4'b0011, 7, 7, 0, 0, 8'h11, 8'h22, 0, 0, 4'b0001, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0010, 4'b0010, 0, 7, 0, 0, 0, 8'h22, 0, 0, 4'b0010, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 7, 0, 0, 0, 0, 4'b1000, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 8'h22));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(4'b1111, 4'b1111, 10, 11, 12, 13, 8'h40, 8'h41, 8'h42, 8'h43,
                             (k % 2 == 0) ? 4'b0011 : 4'b1100, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b1100, 4'b0000, 0, 0, 13, 10, 0, 0, 0, 0, 4'b0100, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 10, 0, 0, 0, 0, 4'b1000, 4'b0100, 8'h43));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 8'h40));
        tbl.push_back(mk(4'b0011, 4'b0010, 12, 14, 0, 0, 0, 8'h55, 0, 0, 4'b0011, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 8'h42));
        tbl.push_back(mk(4'b1100, 4'b0100, 0, 0, 15, 14, 0, 0, 8'h66, 0, 4'b1100, 4'b0000, 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 8'h55));

        foreach (tbl[t]) begin
            cv = tbl[t];
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++)
                drive(i, cv.v[i], cv.wr[i] ? 16'hFFFF : 16'h0, cv.addr[i], {16{cv.wb[i]}});
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", t), 128'(bus.req_ready), 128'(cv.ready));
            chk($sformatf("tbl%0d_rsp_valid", t), 128'(bus.rsp_valid), 128'(cv.rsp));
            if (cv.rsp != 4'b0000)
                chk($sformatf("tbl%0d_rsp_rdata", t), bus.rsp_rdata, {16{cv.rb}});
        end

        // Out-of-range read: accepted, no SRAM access, zero data, sticky error
        @(posedge clk); #1;
        idle_all();
        drive(0, 1'b1, 16'h0, 16'h1000, 128'h0);
        @(negedge clk);
        chk("oob_ready", 128'(bus.req_ready), 128'h1);
        chk("oob_sram_wea0", 128'(sram_wea0), 128'h0);
        chk("oob_sram_addr0", 128'(sram_addr0), 128'h0);
        chk("oob_err_before", 128'(oob_err), 128'h0);
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
        chk("oob_rsp_valid", 128'(bus.rsp_valid), 128'h1);
        chk("oob_rsp_rdata", bus.rsp_rdata, 128'h0);
        chk("oob_err_set", 128'(oob_err), 128'h1);
        @(negedge clk);
        chk("oob_err_sticky", 128'(oob_err), 128'h1);

        // Reset with a read in flight
        @(posedge clk); #1;
        drive(1, 1'b1, 16'h0, 16'd5, 128'h0);
        @(negedge clk);
        chk("rst_pre_ready", 128'(bus.req_ready), 128'h2);
        @(posedge clk); #1;
        idle_all();
        chk("rst_inflight", 128'(bus.rsp_valid), 128'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rsp_drop", 128'(bus.rsp_valid), 128'h0);
        chk("rst_oob_clear", 128'(oob_err), 128'h0);
        for (int i = 0; i < NR; i++) drive(i, 1'b1, 16'h0, 16'd5, 128'h0);
        #1;
        chk("rst_ready_low", 128'(bus.req_ready), 128'h0);
        @(negedge clk);
        chk("rst_no_rsp", 128'(bus.rsp_valid), 128'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_ptr_zero", 128'(bus.req_ready), 128'h1);
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
        chk("rst_post_rsp", 128'(bus.rsp_valid), 128'h1);
        chk("rst_post_rdata", bus.rsp_rdata, {16{8'hA5}});

        // Randomized traffic against the reference model
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0; m_oob = 1'b0; m_rsp_v = 4'b0; m_rsp_d = 128'h0; m_acc = 4'b0; p_v = 4'b0;
        for (int i = 0; i < NR; i++) begin
            p_wr[i] = 1'b0; p_be[i] = 16'h0; p_addr[i] = 16'h0; p_wd[i] = 128'h0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (m_acc[i]) p_v[i] = 1'b0;
                if (!p_v[i] && $urandom_range(0, 3) != 0) begin
                    p_v[i]    = 1'b1;
                    p_wr[i]   = 1'($urandom_range(0, 1));
                    p_be[i]   = p_wr[i] ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0;
                    p_addr[i] = ($urandom_range(0, 15) == 0) ? 16'h1000 + 16'($urandom_range(0, 255))
                                                             : 16'(32 + $urandom_range(0, 3));
                    p_wd[i]   = {$urandom, $urandom, $urandom, $urandom};
                end
                drive(i, p_v[i], p_be[i], p_addr[i], p_wd[i]);
            end
            @(negedge clk);
            chk("rnd_rsp_valid", 128'(bus.rsp_valid), 128'(m_rsp_v));
            if (m_rsp_v != 4'b0) chk("rnd_rsp_rdata", bus.rsp_rdata, m_rsp_d);
            chk("rnd_oob_err", 128'(oob_err), 128'(m_oob));

            // Order pending requesters by ring position from the pointer
            q.delete();
            for (int k = 0; k < NR; k++) begin
                ix = (m_ptr + k) % NR;
                if (p_v[ix]) q.push_back(ix);
            end
            m_acc = 4'b0;
            if (q.size() > 0) begin
                a = q[0];
                m_acc[a] = 1'b1;
                last = a;
                if (q.size() > 1) begin
                    b = q[1];
                    haz = (p_addr[a] == p_addr[b]) && (p_wr[a] || p_wr[b]);
                    if (!haz && (p_wr[a] || p_wr[b])) begin
                        m_acc[b] = 1'b1;
                        last = b;
                    end
                end
                m_ptr = (last + 1) % NR;
            end
            chk("rnd_ready", 128'(bus.req_ready), 128'(m_acc));

            m_rsp_v = 4'b0;
            for (int i = 0; i < NR; i++) begin
                if (m_acc[i]) begin
                    if (p_addr[i] >= 16'd4096) begin
                        m_oob = 1'b1;
                        if (!p_wr[i]) begin m_rsp_v[i] = 1'b1; m_rsp_d = 128'h0; end
                    end else if (!p_wr[i]) begin
                        m_rsp_v[i] = 1'b1;
                        m_rsp_d = shadow[p_addr[i][11:0]];
                    end else begin
                        shadow[p_addr[i][11:0]] = merge(shadow[p_addr[i][11:0]], p_wd[i], p_be[i]);
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
